inst_encoder: RTL

//  Streaming RV32I instruction encoder: the inverse of the immediate decode path. Packs

---
 rtl/inst_encoder.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder.
// Packs opcode/register/funct fields and a signed immediate into a 32-bit instruction
// word for the selected format and flags immediates that do not fit or are misaligned.
// Valid/ready on both sides, one output register plus one skid register, 1-cycle latency.
module inst_encoder #(
    parameter bit          CHECK_EN  = 1'b1,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           fmt,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          inst,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_SB  = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_UJ  = 3'd5;
    localparam logic [2:0] FMT_CSR = 3'd6;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Per-format encodings and raw range/alignment flags
    logic [31:0] word_r;
    logic [31:0] word_i;
    logic [31:0] word_s;
    logic [31:0] word_sb;
    logic [31:0] word_u;
    logic [31:0] word_uj;
    logic [31:0] word_csr;
    logic        rng_12;
    logic        rng_13;
    logic        rng_21;
    logic        bad_i;
    logic        bad_sb;
    logic        bad_u;
    logic        bad_uj;
    logic        bad_csr;

    // Selected encoding for the word presented this cycle
    logic [31:0] enc_word;
    logic        enc_bad;
    logic        enc_err;

    // Output and skid storage
    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_inst_q, out_inst_d;
    logic                 out_err_q, out_err_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [31:0]          skid_inst_q, skid_inst_d;
    logic                 skid_err_q, skid_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic accept;
    logic out_free;
    logic out_fire;

    // Register-register format: immediate is not used
    always_comb begin
        word_r = {funct7, rs2, rs1, funct3, rd, opcode};
    end

    // I and S formats share the 12-bit signed range
    always_comb begin
        word_i = {imm[11:0], rs1, funct3, rd, opcode};
        word_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        // Value fits in 12 signed bits when bits 31..11 are a pure sign extension
        rng_12 = (&imm[31:11]) | ~(|imm[31:11]);
        bad_i  = ~rng_12;
    end

    // Branch format: 13-bit signed, even byte offset
    always_comb begin
        word_sb = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        rng_13  = (&imm[31:12]) | ~(|imm[31:12]);
        bad_sb  = ~rng_13 | imm[0];
    end

    // Upper-immediate format: low 12 bits must be zero
    always_comb begin
        word_u = {imm[31:12], rd, opcode};
        bad_u  = |imm[11:0];
    end

    // Jump format: 21-bit signed, even byte offset
    always_comb begin
        word_uj = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        rng_21  = (&imm[31:20]) | ~(|imm[31:20]);
        bad_uj  = ~rng_21 | imm[0];
    end

    // CSR format: imm carries {csr address, zimm} as an unsigned 17-bit value
    always_comb begin
        word_csr = {imm[16:5], imm[4:0], funct3, rd, opcode};
        bad_csr  = |imm[31:17];
    end

    // Format select; the invalid format always yields a flagged NOP
    always_comb begin
        enc_word = NOP_WORD;
        enc_bad  = 1'b0;
        enc_err  = 1'b1;
        case (fmt)
            FMT_R: begin
                enc_word = word_r;
                enc_bad  = 1'b0;
            end
            FMT_I: begin
                enc_word = word_i;
                enc_bad  = bad_i;
            end
            FMT_S: begin
                enc_word = word_s;
                enc_bad  = bad_i;
            end
            FMT_SB: begin
                enc_word = word_sb;
                enc_bad  = bad_sb;
            end
            FMT_U: begin
                enc_word = word_u;
                enc_bad  = bad_u;
            end
            FMT_UJ: begin
                enc_word = word_uj;
                enc_bad  = bad_uj;
            end
            FMT_CSR: begin
                enc_word = word_csr;
                enc_bad  = bad_csr;
            end
            default: begin
                enc_word = NOP_WORD;
                enc_bad  = 1'b1;
            end
        endcase
        if (fmt == 3'd7) begin
            enc_err = 1'b1;
        end else begin
            enc_err = CHECK_EN ? enc_bad : 1'b0;
        end
    end

    // Handshake qualifiers; ready depends only on stored state so it never loops back
    always_comb begin
        in_ready = ~rst & ~skid_valid_q;
        accept   = in_valid & in_ready;
        out_free = ~out_valid_q | out_ready;
        out_fire = out_valid_q & out_ready;
    end

    // Next-state for output register, skid register and error counter
    always_comb begin
        out_valid_d  = out_valid_q;
        out_inst_d   = out_inst_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_err_d   = skid_err_q;
        err_cnt_d    = err_cnt_q;

        if (out_free) begin
            if (skid_valid_q) begin
                // Older skid word goes first; no accept is possible while skid is full
                out_valid_d  = 1'b1;
                out_inst_d   = skid_inst_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_inst_d  = enc_word;
                out_err_d   = enc_err;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_inst_d  = enc_word;
            skid_err_d   = enc_err;
        end

        if (out_fire && out_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with synchronous reset that drops any buffered words
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_inst_q   <= 32'h0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= 32'h0;
            skid_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_err_q   <= skid_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign inst      = out_inst_q;
    assign err       = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
